// File: rtl/seven_segment_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seven_segment_capture
// Purpose  : Rebuilds the four BCD digits shown on a multiplexed, active-low
//            7-segment display by watching its segment and anode lines.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_capture #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits_out,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        decode_err,
  output logic        an_err
);

  localparam logic [1:0]  c_IDLE     = 2'd0;
  localparam logic [1:0]  c_SETTLE   = 2'd1;
  localparam logic [1:0]  c_HOLD     = 2'd2;
  localparam logic [7:0]  c_SETTLE_N = 8'(SETTLE_CYCLES);
  localparam logic [23:0] c_TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0] c_IDLE_MAX = 24'hFF_FFFF;

  logic [6:0]  r_seg_s1, r_seg_s2;
  logic [3:0]  r_an_s1, r_an_s2;
  logic [10:0] r_prev;
  logic [1:0]  r_state;
  logic [7:0]  r_settle_cnt;
  logic [23:0] r_idle_cnt;
  logic [3:0]  r_mask;

  logic [10:0] w_cur;
  logic        w_change;
  logic        w_sample;
  logic        w_onehot;
  logic        w_multi;
  logic [1:0]  w_idx;
  logic [3:0]  w_sel;
  logic [3:0]  w_mask_next;
  logic [3:0]  w_nib;
  logic        w_bad;

  // Synchronizers idle at all-ones so reset looks like a dark display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_s1 <= 7'h7F;
      r_seg_s2 <= 7'h7F;
      r_an_s1  <= 4'hF;
      r_an_s2  <= 4'hF;
      r_prev   <= 11'h7FF;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_an_s1  <= an_in;
      r_an_s2  <= r_an_s1;
      r_prev   <= w_cur;
    end
  end

  assign w_cur    = {r_an_s2, r_seg_s2};
  assign w_change = (w_cur != r_prev);
  assign w_sample = (r_state == c_SETTLE) && !w_change && (r_settle_cnt == c_SETTLE_N);

  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (r_an_s2)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  assign w_multi     = !w_onehot && (r_an_s2 != 4'hF);
  assign w_sel       = w_onehot ? ~r_an_s2 : 4'h0;
  assign w_mask_next = r_mask | w_sel;

  always_comb begin
    w_bad = 1'b0;
    w_nib = 4'hE;
    case (r_seg_s2)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h7F: w_nib = 4'hF;
      default: w_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_settle_cnt <= 8'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (r_an_s2 != 4'hF) begin
            r_state      <= c_SETTLE;
            r_settle_cnt <= 8'd1;
          end
        end
        c_SETTLE: begin
          if (w_change) begin
            r_state      <= (r_an_s2 == 4'hF) ? c_IDLE : c_SETTLE;
            r_settle_cnt <= 8'd1;
          end else if (r_settle_cnt == c_SETTLE_N) begin
            r_state <= c_HOLD;
          end else begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
          end
        end
        c_HOLD: begin
          if (w_change) begin
            r_state      <= (r_an_s2 == 4'hF) ? c_IDLE : c_SETTLE;
            r_settle_cnt <= 8'd1;
          end
        end
        default: begin
          r_state      <= c_IDLE;
          r_settle_cnt <= 8'd0;
        end
      endcase
    end
  end

  // A one-hot sample overrides a timeout landing in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_out  <= 16'hFFFF;
      digit_valid <= 4'h0;
      frame_valid <= 1'b0;
      decode_err  <= 1'b0;
      an_err      <= 1'b0;
      r_idle_cnt  <= 24'd0;
      r_mask      <= 4'h0;
    end else begin
      frame_valid <= 1'b0;
      decode_err  <= 1'b0;
      an_err      <= 1'b0;
      if (r_idle_cnt != c_IDLE_MAX) begin
        r_idle_cnt <= r_idle_cnt + 24'd1;
      end
      if (r_idle_cnt == c_TMO_LAST) begin
        digit_valid <= 4'h0;
        r_mask      <= 4'h0;
      end
      if (w_sample && w_onehot) begin
        digits_out[{w_idx, 2'b00} +: 4] <= w_nib;
        digit_valid <= digit_valid | w_sel;
        decode_err  <= w_bad;
        r_idle_cnt  <= 24'd0;
        if (w_mask_next == 4'hF) begin
          frame_valid <= 1'b1;
          r_mask      <= 4'h0;
        end else begin
          r_mask      <= w_mask_next;
        end
      end else if (w_sample && w_multi) begin
        an_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_capture
// Purpose  : Scoreboard bench for seven_segment_capture driving display dwells.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_capture;

  localparam int SETTLE = 16;
  localparam int TMO    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digits_out;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        decode_err;
  logic        an_err;

  seven_segment_capture #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits_out  (digits_out),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .decode_err  (decode_err),
    .an_err      (an_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  valid;
    int          frame;
    int          derr;
    int          aerr;
    int          chg;
    logic        cap;
    logic        tmo;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_digits = 16'hFFFF;
  logic [3:0]  m_valid  = 4'h0;
  logic [3:0]  m_mask   = 4'h0;
  int          last_cap = 0;

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    case (s)
      7'h40: return 5'h00;
      7'h79: return 5'h01;
      7'h24: return 5'h02;
      7'h30: return 5'h03;
      7'h19: return 5'h04;
      7'h12: return 5'h05;
      7'h02: return 5'h06;
      7'h78: return 5'h07;
      7'h00: return 5'h08;
      7'h10: return 5'h09;
      7'h7F: return 5'h0F;
      default: return 5'h1E;
    endcase
  endfunction

  task automatic push_expect(input logic [3:0] an, input logic [6:0] seg, input int cycles);
    exp_t        e;
    logic [15:0] d0 = m_digits;
    logic [3:0]  v0 = m_valid;
    logic [4:0]  r;
    int          zeros = 0;
    int          k = 0;
    e.frame = 0; e.derr = 0; e.aerr = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) begin zeros++; k = i; end
    if (zeros == 0) begin
      if (cycles > TMO) begin m_valid = 4'h0; m_mask = 4'h0; end
    end else if (zeros == 1) begin
      r = ref_decode(seg);
      m_digits[k*4 +: 4] = r[3:0];
      e.derr     = r[4] ? 1 : 0;
      m_valid[k] = 1'b1;
      m_mask[k]  = 1'b1;
      if (m_mask == 4'hF) begin e.frame = 1; m_mask = 4'h0; end
    end else begin
      e.aerr = 1;
    end
    e.digits = m_digits;
    e.valid  = m_valid;
    e.chg    = ({m_digits, m_valid} != {d0, v0}) ? 1 : 0;
    e.cap    = (an != 4'hF) && (e.chg == 1);
    e.tmo    = (an == 4'hF) && (e.chg == 1);
    sb.push_back(e);
  endtask

  // Holds one anode/segment pattern and observes every cycle of the dwell
  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int cycles,
                       input int glitch_at, input logic [6:0] glitch_seg);
    exp_t        e;
    int          t0, frame_n, derr_n, aerr_n, chg_n, chg_edge, frame_edge;
    logic [19:0] prev;
    frame_n = 0; derr_n = 0; aerr_n = 0; chg_n = 0; chg_edge = -1; frame_edge = -1;
    push_expect(an, seg, cycles);
    prev  = {digits_out, digit_valid};
    an_in = an;
    seg_in = seg;
    t0 = cyc;
    for (int i = 0; i < cycles; i++) begin
      if (i == glitch_at) seg_in = glitch_seg;
      if (glitch_at >= 0 && i == glitch_at + 1) begin seg_in = seg; t0 = cyc; end
      @(negedge clk);
      if (frame_valid) begin frame_n++; frame_edge = cyc; end
      if (decode_err) derr_n++;
      if (an_err) aerr_n++;
      if ({digits_out, digit_valid} != prev) begin
        chg_n++;
        if (chg_edge < 0) chg_edge = cyc;
      end
      prev = {digits_out, digit_valid};
    end
    e = sb.pop_front();
    check_value("digits_out", digits_out, e.digits);
    check_value("digit_valid", digit_valid, e.valid);
    check_value("frame_pulses", frame_n, e.frame);
    check_value("decode_err_pulses", derr_n, e.derr);
    check_value("an_err_pulses", aerr_n, e.aerr);
    check_value("captures_in_dwell", chg_n, e.chg);
    if (e.cap) begin
      check_value("capture_latency", chg_edge - t0, SETTLE + 3);
      last_cap = chg_edge;
    end
    if (e.frame == 1 && e.cap) check_value("frame_with_update", frame_edge, chg_edge);
    if (e.tmo) check_value("timeout_delay", chg_edge - last_cap, TMO);
  endtask

  initial begin
    rst    = 1'b1;
    seg_in = 7'h7F;
    an_in  = 4'hF;
    repeat (3) @(negedge clk);
    check_value("rst_digits", digits_out, 16'hFFFF);
    check_value("rst_valid", digit_valid, 4'h0);
    check_value("rst_frame", frame_valid, 1'b0);
    check_value("rst_decode_err", decode_err, 1'b0);
    check_value("rst_an_err", an_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    dwell(4'b1110, 7'h30, 40, -1, 7'h00);

    repeat (2) begin
      dwell(4'b1110, 7'h79, 32, -1, 7'h00);
      dwell(4'b1101, 7'h24, 32, -1, 7'h00);
      dwell(4'b1011, 7'h30, 32, -1, 7'h00);
      dwell(4'b0111, 7'h19, 32, -1, 7'h00);
    end

    dwell(4'b1101, 7'h19, 41, 10, 7'h00);
    dwell(4'b1011, 7'h55, 32, -1, 7'h00);
    dwell(4'b1100, 7'h40, 20, -1, 7'h00);

    dwell(4'b0111, 7'h40, 32, -1, 7'h00);
    dwell(4'b1111, 7'h7F, 80, -1, 7'h00);

    dwell(4'b1110, 7'h79, 32, -1, 7'h00);
    dwell(4'b1101, 7'h24, 32, -1, 7'h00);
    rst    = 1'b1;
    an_in  = 4'hF;
    seg_in = 7'h7F;
    #1;
    check_value("async_rst_digits", digits_out, 16'hFFFF);
    check_value("async_rst_valid", digit_valid, 4'h0);
    check_value("async_rst_frame", frame_valid, 1'b0);
    m_digits = 16'hFFFF;
    m_valid  = 4'h0;
    m_mask   = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    dwell(4'b1110, 7'h79, 32, -1, 7'h00);
    dwell(4'b1101, 7'h24, 32, -1, 7'h00);
    dwell(4'b1011, 7'h30, 32, -1, 7'h00);
    dwell(4'b0111, 7'h19, 32, -1, 7'h00);

    check_value("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
